// File: rtl/n64_poll_multi.sv
// Round-robin N64 controller poller: sends the 0x01 status command on each open-drain
// pad line in turn, receives the 32-bit reply and keeps a status word and presence flag per port.
module n64_poll_multi #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned US_CYCLES  = 50,
  parameter int unsigned TIMEOUT_US = 8,
  parameter int unsigned GAP_US     = 1000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic [NUM_PORTS-1:0]      data_in,
  output logic [NUM_PORTS-1:0]      data_oe,
  output logic [32*NUM_PORTS-1:0]   buttons,
  output logic [NUM_PORTS-1:0]      present,
  output logic                      valid,
  output logic                      error,
  output logic [7:0]                port_idx
);

  localparam int unsigned CELL   = 4 * US_CYCLES;
  localparam int unsigned TMO    = TIMEOUT_US * US_CYCLES;
  localparam int unsigned GAPC   = GAP_US * US_CYCLES;
  localparam int unsigned SMP    = 2 * US_CYCLES;
  localparam int unsigned CMAX_A = (GAPC > CELL) ? GAPC : CELL;
  localparam int unsigned CMAX   = (CMAX_A > TMO) ? CMAX_A : TMO;
  localparam int unsigned CW     = $clog2(CMAX + 1);
  localparam logic [7:0]  CMD    = 8'h01;

  typedef enum logic [3:0] {
    S_IDLE, S_TX, S_TX_STOP, S_RX_WAIT, S_RX_SAMPLE, S_RX_HIGH, S_DONE, S_FAIL, S_GAP
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [4:0]           bitn;
  logic [31:0]          shreg;
  logic [NUM_PORTS-1:0] sync1, sync2;
  logic                 line, line_d;
  logic                 fall_c, cmd_bit_c;
  logic                 oe_c, cnt_clr_c, cnt_inc_c, bit_clr_c, bit_inc_c;
  logic                 shift_c, ok_c, fail_c, adv_c;

  // Synchronized level of the port currently being polled
  always_comb begin
    line = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_idx == 8'(i)) line = sync2[i];
    end
  end

  assign fall_c    = line_d & ~line;
  assign cmd_bit_c = CMD[3'd7 - bitn[2:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (enable) state_nxt = S_TX;
      S_TX:        if (cnt == CW'(CELL - 1) && bitn == 5'd7) state_nxt = S_TX_STOP;
      S_TX_STOP:   if (cnt == CW'(US_CYCLES - 1)) state_nxt = S_RX_WAIT;
      S_RX_WAIT: begin
        if (fall_c)                    state_nxt = S_RX_SAMPLE;
        else if (cnt == CW'(TMO - 1))  state_nxt = S_FAIL;
      end
      S_RX_SAMPLE: if (cnt == CW'(SMP - 1)) state_nxt = (bitn == 5'd31) ? S_DONE : S_RX_HIGH;
      S_RX_HIGH: begin
        if (line)                      state_nxt = S_RX_WAIT;
        else if (cnt == CW'(TMO - 1))  state_nxt = S_FAIL;
      end
      S_DONE:      state_nxt = S_GAP;
      S_FAIL:      state_nxt = S_GAP;
      S_GAP:       if (cnt == CW'(GAPC - 1)) state_nxt = enable ? S_TX : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Per-state line drive and datapath strobes
  always_comb begin
    oe_c      = 1'b0;
    cnt_clr_c = 1'b0;
    cnt_inc_c = 1'b0;
    bit_clr_c = 1'b0;
    bit_inc_c = 1'b0;
    shift_c   = 1'b0;
    ok_c      = 1'b0;
    fail_c    = 1'b0;
    adv_c     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr_c = 1'b1;
        bit_clr_c = 1'b1;
      end
      S_TX: begin
        oe_c = cmd_bit_c ? (cnt < CW'(US_CYCLES)) : (cnt < CW'(3 * US_CYCLES));
        if (cnt == CW'(CELL - 1)) begin
          cnt_clr_c = 1'b1;
          if (bitn == 5'd7) bit_clr_c = 1'b1;
          else              bit_inc_c = 1'b1;
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      S_TX_STOP: begin
        oe_c = 1'b1;
        if (cnt == CW'(US_CYCLES - 1)) cnt_clr_c = 1'b1;
        else                           cnt_inc_c = 1'b1;
      end
      S_RX_WAIT: begin
        if (fall_c) cnt_clr_c = 1'b1;
        else        cnt_inc_c = 1'b1;
      end
      S_RX_SAMPLE: begin
        if (cnt == CW'(SMP - 1)) begin
          shift_c   = 1'b1;
          bit_inc_c = 1'b1;
          cnt_clr_c = 1'b1;
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      S_RX_HIGH: begin
        if (line) cnt_clr_c = 1'b1;
        else      cnt_inc_c = 1'b1;
      end
      S_DONE: begin
        ok_c      = 1'b1;
        cnt_clr_c = 1'b1;
      end
      S_FAIL: begin
        fail_c    = 1'b1;
        cnt_clr_c = 1'b1;
      end
      S_GAP: begin
        if (cnt == CW'(GAPC - 1)) begin
          adv_c     = 1'b1;
          cnt_clr_c = 1'b1;
          bit_clr_c = 1'b1;
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      default: cnt_clr_c = 1'b1;
    endcase
  end

  // Registered datapath; status slices are written whole in the DONE/FAIL cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1    <= '1;
      sync2    <= '1;
      line_d   <= 1'b1;
      cnt      <= '0;
      bitn     <= '0;
      shreg    <= '0;
      data_oe  <= '0;
      buttons  <= '0;
      present  <= '0;
      valid    <= 1'b0;
      error    <= 1'b0;
      port_idx <= '0;
    end else begin
      sync1  <= data_in;
      sync2  <= sync1;
      line_d <= line;
      if (cnt_clr_c)      cnt <= '0;
      else if (cnt_inc_c) cnt <= cnt + CW'(1);
      if (bit_clr_c)      bitn <= '0;
      else if (bit_inc_c) bitn <= bitn + 5'd1;
      if (shift_c) shreg <= {shreg[30:0], line};
      valid <= ok_c;
      error <= fail_c;
      for (int p = 0; p < NUM_PORTS; p++) begin
        data_oe[p] <= oe_c && (port_idx == 8'(p));
        if (port_idx == 8'(p)) begin
          if (ok_c) begin
            buttons[32*p +: 32] <= shreg;
            present[p]          <= 1'b1;
          end else if (fail_c) begin
            buttons[32*p +: 32] <= '0;
            present[p]          <= 1'b0;
          end
        end
      end
      if (adv_c) port_idx <= (port_idx == 8'(NUM_PORTS - 1)) ? 8'd0 : port_idx + 8'd1;
    end
  end

endmodule
